// File: rtl/glyph_row_streamer.sv
// glyph_row_streamer
//   Read-side client of the digit-glyph ROM mux. Latches the digit to draw once
//   per frame and computes the glyph row index at the start of each line. On
//   glyph lines it captures the 64-bit row just before the glyph's left edge and
//   shifts it out MSB-first, one pixel per pix_en tick. pixel_on/glyph_active lag
//   hcount by one tick.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   pix_en       in   pixel-tick enable; all state advances only when high
//   hcount       in   [9:0] horizontal pixel count
//   vcount       in   [9:0] vertical line count
//   digit_in     in   [3:0] digit to draw (0..8 glyphs, 9..15 draw nothing)
//   mux_digit    out  [3:0] frame-latched digit select to the glyph ROM mux
//   mux_index_Y  out  [5:0] row index to the glyph ROM mux
//   mux_spo      in   [63:0] row data returned by the glyph ROM mux
//   pixel_on     out  current glyph pixel, 1 = foreground
//   glyph_active out  high while pixel_on lies inside the 64x64 glyph box

module glyph_row_streamer #(
  parameter int ORIGIN_X = 288,
  parameter int ORIGIN_Y = 208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [3:0]  digit_in,
  output logic [3:0]  mux_digit,
  output logic [5:0]  mux_index_Y,
  input  logic [63:0] mux_spo,
  output logic        pixel_on,
  output logic        glyph_active
);

  // The row is captured one tick before the left edge so bit 63 appears on
  // the tick where hcount == ORIGIN_X.
  localparam logic [9:0] X_ARM = 10'(ORIGIN_X - 1);
  localparam logic [9:0] Y_LO  = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI  = 10'(ORIGIN_Y + 63);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e       state_q,   state_d;
  logic [3:0]   digit_q,   digit_d;
  logic [5:0]   row_q,     row_d;
  logic         row_hit_q, row_hit_d;
  logic [63:0]  shreg_q,   shreg_d;
  logic [6:0]   bit_cnt_q, bit_cnt_d;
  logic         pixel_q,   pixel_d;
  logic         active_q,  active_d;

  logic         in_rows_s;
  logic         line_start_s;

  assign in_rows_s    = (vcount >= Y_LO) && (vcount <= Y_HI);
  assign line_start_s = (hcount == 10'd0);

  assign mux_digit    = digit_q;
  assign mux_index_Y  = row_q;
  assign pixel_on     = pixel_q;
  assign glyph_active = active_q;

  // Next-state logic: frame latch, row index and the streaming FSM.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    row_d     = row_q;
    row_hit_d = row_hit_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pixel_d   = pixel_q;
    active_d  = active_q;

    if (pix_en) begin
      // Digit only changes at the top-left of the frame so a glyph never tears.
      if (line_start_s && (vcount == 10'd0)) begin
        digit_d = digit_in;
      end else begin
        digit_d = digit_q;
      end

      // Index is stable from hcount 0 until the capture at ORIGIN_X-1.
      if (line_start_s) begin
        row_d     = 6'(vcount - Y_LO);
        row_hit_d = in_rows_s;
      end else begin
        row_d     = row_q;
        row_hit_d = row_hit_q;
      end

      case (state_q)
        IDLE: begin
          pixel_d  = 1'b0;
          active_d = 1'b0;
          if (line_start_s && in_rows_s) begin
            state_d = ARMED;
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          pixel_d  = 1'b0;
          active_d = 1'b0;
          if (line_start_s) begin
            // Line ended early: give up on this row.
            state_d = IDLE;
          end else if (hcount == X_ARM) begin
            if (row_hit_q) begin
              shreg_d   = mux_spo;
              bit_cnt_d = 7'd64;
              state_d   = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = ARMED;
          end
        end
        SHIFT: begin
          if (line_start_s) begin
            pixel_d  = 1'b0;
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            // Digits 9..15 keep the box timing but never light a pixel.
            pixel_d   = shreg_q[63] & (digit_q <= 4'd8);
            active_d  = 1'b1;
            shreg_d   = {shreg_q[62:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 7'd1;
            if (bit_cnt_q == 7'd1) begin
              state_d = DRAIN;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        DRAIN: begin
          pixel_d  = 1'b0;
          active_d = 1'b0;
          state_d  = IDLE;
        end
        default: begin
          pixel_d  = 1'b0;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      digit_q   <= 4'd0;
      row_q     <= 6'd0;
      row_hit_q <= 1'b0;
      shreg_q   <= 64'd0;
      bit_cnt_q <= 7'd0;
      pixel_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      row_q     <= row_d;
      row_hit_q <= row_hit_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      pixel_q   <= pixel_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: tb/tb_glyph_row_streamer.sv
// Self-checking bench for glyph_row_streamer. A behavioural ROM model feeds
// mux_spo; every pixel tick pushes the expected outputs to a scoreboard queue
// and pops/compares them one clock later.

module tb_glyph_row_streamer;

  localparam int OX  = 288;
  localparam int OY  = 208;
  localparam int LEN = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [3:0]  digit_in;
  logic [3:0]  mux_digit;
  logic [5:0]  mux_index_Y;
  logic [63:0] mux_spo;
  logic        pixel_on;
  logic        glyph_active;
  bit          force_ones;

  always #5 clk = ~clk;

  glyph_row_streamer #(.ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .hcount       (hcount),
    .vcount       (vcount),
    .digit_in     (digit_in),
    .mux_digit    (mux_digit),
    .mux_index_Y  (mux_index_Y),
    .mux_spo      (mux_spo),
    .pixel_on     (pixel_on),
    .glyph_active (glyph_active)
  );

  function automatic logic [63:0] rom_model(input logic [3:0] d, input logic [5:0] r, input bit ones);
    logic [15:0] w;
    if (ones) return {64{1'b1}};
    if (d > 4'd8) return 64'd0;
    if (d == 4'd3 && r == 6'd5) return 64'hF000_0000_0000_0001;
    w = {d, r, ~r};
    return {4{w}};
  endfunction

  always_comb mux_spo = rom_model(mux_digit, mux_index_Y, force_ones);

  typedef struct {
    logic       pix;
    logic       act;
    logic [5:0] idx;
    logic [3:0] dig;
  } exp_t;

  typedef struct {
    logic [3:0] digit;
    int         v;
    bit         ones;
    int         div;
    int         exp_on;
    int         exp_act;
    logic [5:0] exp_idx;
  } vec_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int on_cnt   = 0;
  int act_cnt  = 0;

  // Reference model state
  logic [3:0]  m_digit;
  logic [5:0]  m_idx;
  bit          m_armed;
  logic [63:0] m_row;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t h=%0d v=%0d)", name, got, want, $time, hcount, vcount);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb_q.pop_front();
    check("pixel_on",     64'(pixel_on),     64'(e.pix));
    check("glyph_active", 64'(glyph_active), 64'(e.act));
    check("mux_index_Y",  64'(mux_index_Y),  64'(e.idx));
    check("mux_digit",    64'(mux_digit),    64'(e.dig));
  endtask

  task automatic tick(input int h, input int v, input int div);
    exp_t e;
    if (h == 0) begin
      m_idx   = 6'((v - OY) & 63);
      m_armed = (v >= OY) && (v <= OY + 63);
      if (v == 0) m_digit = digit_in;
      m_row   = rom_model(m_digit, m_idx, force_ones);
    end
    e.idx = m_idx;
    e.dig = m_digit;
    if (m_armed && h >= OX && h <= OX + 63) begin
      e.act = 1'b1;
      e.pix = (m_digit <= 4'd8) ? m_row[OX + 63 - h] : 1'b0;
    end else begin
      e.act = 1'b0;
      e.pix = 1'b0;
    end
    sb_q.push_back(e);
    hcount = 10'(h);
    vcount = 10'(v);
    pix_en = 1'b1;
    @(posedge clk); #1;
    if (pixel_on) on_cnt++;
    if (glyph_active) act_cnt++;
    compare_front();
    if (div == 2) begin
      // Idle clock: nothing may move.
      sb_q.push_back(e);
      pix_en = 1'b0;
      @(posedge clk); #1;
      compare_front();
    end
  endtask

  task automatic run_line(input int v, input int first, input int len, input int div);
    for (int h = first; h < len; h++) tick(h, v, div);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'd3,  OY + 5,  1'b0, 1, 5,  64, 6'd5};   // single row
    vecs[1] = '{4'd3,  OY + 5,  1'b0, 2, 5,  64, 6'd5};   // pix_en every 2nd clk
    vecs[2] = '{4'd3,  OY - 1,  1'b0, 1, 0,  0,  6'd63};  // line above glyph
    vecs[3] = '{4'd3,  OY + 64, 1'b0, 1, 0,  0,  6'd0};   // line below glyph
    vecs[4] = '{4'd3,  OY + 63, 1'b0, 1, 32, 64, 6'd63};  // last glyph row
    vecs[5] = '{4'd12, OY + 5,  1'b1, 1, 0,  64, 6'd5};   // invalid digit

    reset = 1'b1; pix_en = 1'b0; hcount = 10'd0; vcount = 10'd0;
    digit_in = 4'd0; force_ones = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pixel_on",     64'(pixel_on),     64'd0);
    check("rst_glyph_active", 64'(glyph_active), 64'd0);
    check("rst_mux_index_Y",  64'(mux_index_Y),  64'd0);
    check("rst_mux_digit",    64'(mux_digit),    64'd0);
    reset = 1'b0;
    m_digit = 4'd0; m_idx = 6'd0; m_armed = 1'b0; m_row = 64'd0;

    // Table-driven line scenarios: latch digit on a vcount=0 line, then draw.
    for (int i = 0; i < 6; i++) begin
      digit_in   = vecs[i].digit;
      force_ones = vecs[i].ones;
      run_line(0, 0, LEN, vecs[i].div);
      on_cnt = 0; act_cnt = 0;
      run_line(vecs[i].v, 0, LEN, vecs[i].div);
      check("vec_on_count",  64'(on_cnt),      64'(vecs[i].exp_on));
      check("vec_act_count", 64'(act_cnt),     64'(vecs[i].exp_act));
      check("vec_index",     64'(mux_index_Y), 64'(vecs[i].exp_idx));
      check("vec_digit",     64'(mux_digit),   64'(vecs[i].digit));
    end
    force_ones = 1'b0;

    // Frame latch: mid-frame digit change held until the vcount=0 wrap.
    digit_in = 4'd3;
    run_line(0, 0, LEN, 1);
    digit_in = 4'd7;
    run_line(220, 0, LEN, 1);
    check("frame_hold_digit", 64'(mux_digit), 64'd3);
    tick(0, 0, 1);
    check("frame_latch_digit", 64'(mux_digit),   64'd7);
    check("frame_wrap_index",  64'(mux_index_Y), 64'd48);
    run_line(0, 1, LEN, 1);

    // Short lines: abort out of SHIFT and out of ARMED.
    digit_in = 4'd3;
    run_line(0, 0, LEN, 1);
    run_line(OY + 5, 0, 320, 1);
    tick(0, 300, 1);
    check("abort_shift_active", 64'(glyph_active), 64'd0);
    run_line(300, 1, LEN, 1);
    run_line(OY + 6, 0, 100, 1);
    run_line(300, 0, LEN, 1);
    on_cnt = 0; act_cnt = 0;
    run_line(OY + 6, 0, LEN, 1);
    check("after_abort_act_count", 64'(act_cnt), 64'd64);

    // Reset held 3 clocks mid-SHIFT, then streaming resumes with digit 0.
    run_line(OY + 5, 0, 300, 1);
    reset = 1'b1; pix_en = 1'b1; hcount = 10'd300;
    @(posedge clk); #1;
    check("midrst_pixel_on",     64'(pixel_on),     64'd0);
    check("midrst_glyph_active", 64'(glyph_active), 64'd0);
    check("midrst_mux_index_Y",  64'(mux_index_Y),  64'd0);
    check("midrst_mux_digit",    64'(mux_digit),    64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("midrst_hold_active", 64'(glyph_active), 64'd0);
    end
    reset = 1'b0;
    m_digit = 4'd0; m_idx = 6'd0; m_armed = 1'b0;
    on_cnt = 0; act_cnt = 0;
    run_line(OY + 5, 0, LEN, 1);
    check("resume_on_count",  64'(on_cnt),  64'd24);
    check("resume_act_count", 64'(act_cnt), 64'd64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
